// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 deserialiser with a single-entry holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic [7:0] freq_divider,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SCNT_W  = 4;
  localparam int unsigned BCNT_W  = 3;
  localparam logic [SCNT_W-1:0] LAST_CNT = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK
  } state_t;

  state_t              state;
  logic                sync1, rxs;
  logic [7:0]          tcnt;
  logic                tick;
  logic [SCNT_W-1:0]   scnt;
  logic [BCNT_W-1:0]   bcnt;
  logic [DATA_W-1:0]   shreg;
  logic                decide;
  logic                sample_c;
  logic                load_c;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_bit;
      rxs   <= sync1;
    end
  end

  // Oversample tick generator, period freq_divider+1 clks
  assign tick = (tcnt == freq_divider);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= 8'd0;
    end else if (tick) begin
      tcnt <= 8'd0;
    end else begin
      tcnt <= tcnt + 8'd1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SCNT_W-1:0] DEC_CNT = SCNT_W'(8);
  logic samp6, samp7;

  // Early samples held until the decision tick at scnt==8
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp6 <= 1'b1;
      samp7 <= 1'b1;
    end else if (tick) begin
      if (scnt == SCNT_W'(6)) samp6 <= rxs;
      if (scnt == SCNT_W'(7)) samp7 <= rxs;
    end
  end

  assign sample_c = (samp6 & samp7) | (samp6 & rxs) | (samp7 & rxs);
`else
  localparam logic [SCNT_W-1:0] DEC_CNT = SCNT_W'(7);
  assign sample_c = rxs;
`endif

  assign decide = (scnt == DEC_CNT);
  assign load_c = tick && (state == ST_STOP) && decide && sample_c;

  // Frame FSM; every transition is qualified by tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (!rxs) begin
              state <= ST_START;
              scnt  <= '0;
              busy  <= 1'b1;
            end
          end
          ST_START: begin
            scnt <= scnt + SCNT_W'(1);
            if (decide && sample_c) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (scnt == LAST_CNT) begin
              state <= ST_DATA;
              scnt  <= '0;
              bcnt  <= '0;
            end
          end
          ST_DATA: begin
            scnt <= scnt + SCNT_W'(1);
            if (decide) shreg <= {sample_c, shreg[DATA_W-1:1]};
            if (scnt == LAST_CNT) begin
              scnt <= '0;
              if (bcnt == LAST_BIT) state <= ST_STOP;
              else                  bcnt  <= bcnt + BCNT_W'(1);
            end
          end
          ST_STOP: begin
            scnt <= scnt + SCNT_W'(1);
            if (decide) begin
              if (sample_c) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state     <= ST_BRK;
                frame_err <= 1'b1;
              end
            end
          end
          ST_BRK: begin
            if (rxs) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Holding register; a same-clk consume lets the new byte in without overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (load_c) begin
      data_out   <= shreg;
      data_valid <= 1'b1;
      overrun    <= data_valid && !data_ready;
    end else if (data_ready && data_valid) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of 8N1 frames plus hand-written corner sequences, scoreboard on byte loads.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx_bit;
  logic [7:0] freq_divider;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .freq_divider (freq_divider),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  localparam int BIT_CLKS = 64;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int unsigned pcnt;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_out = 8'h00;
  logic       prev_ferr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since reset release; tick lands on multiples of 4 with freq_divider=3
  always @(posedge clk or negedge reset) begin
    if (!reset) pcnt <= 0;
    else        pcnt <= pcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each new held byte is compared against the oldest expected byte
  always @(negedge clk) begin
    if (reset) begin
      if (data_valid && (!prev_valid || data_out != prev_out)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h expected=none at %0t", data_out, $time);
        end else begin
          chk("rx_byte", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) begin
        ferr_cnt++;
        chk("ferr_width", 32'(prev_ferr), 32'd0);
      end
    end
    prev_valid = data_valid;
    prev_out   = data_out;
    prev_ferr  = frame_err;
  end

  // Frame bit j, offset o is driven on the negedge after posedge k+64j+o, k = pcnt at start
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_j,
                            input int abort_j);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    while (pcnt % 4 != 1) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      for (int o = 0; o < BIT_CLKS; o++) begin
        if (j == abort_j && o == 32) begin
          reset = 1'b0;
          #1;
          chk("rst_data_out", 32'(data_out), 32'h00);
          chk("rst_valid", 32'(data_valid), 32'd0);
          chk("rst_overrun", 32'(overrun), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_ferr", 32'(frame_err), 32'd0);
          return;
        end
        rx_bit = (j == glitch_j && o >= 31 && o <= 34) ? 1'b1 : bits[j];
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx_bit = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic consume();
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int f0;
    logic [7:0] gexp;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hC3, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 0};

    reset = 1'b0;
    rx_bit = 1'b1;
    data_ready = 1'b0;
    freq_divider = 8'd3;
    #1;
    chk("init_data_out", 32'(data_out), 32'h00);
    chk("init_valid", 32'(data_valid), 32'd0);
    chk("init_ferr", 32'(frame_err), 32'd0);
    chk("init_overrun", 32'(overrun), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(40);

    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, -1, -1);
      idle(BIT_CLKS);
      chk("vec_valid", 32'(data_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk("vec_data", 32'(data_out), 32'(vecs[i].data));
      chk("vec_ferr", 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      chk("vec_busy", 32'(busy), 32'd0);
      chk("vec_queue", 32'(exp_q.size()), 32'd0);
      if (data_valid) begin
        consume();
        chk("vec_consumed", 32'(data_valid), 32'd0);
      end
    end

    // Short low glitch on an idle line must abort as a false start
    @(negedge clk);
    rx_bit = 1'b0;
    repeat (16) @(negedge clk);
    rx_bit = 1'b1;
    chk("glitch_started", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("glitch_busy", 32'(busy), 32'd0);
    idle(BIT_CLKS);
    chk("glitch_valid", 32'(data_valid), 32'd0);

    // Bad stop bit followed by a 3-bit break, then a good frame
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, -1);
    rx_bit = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("break_busy", 32'(busy), 32'd1);
    chk("break_valid", 32'(data_valid), 32'd0);
    idle(BIT_CLKS);
    chk("break_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("break_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, -1);
    idle(16);
    chk("after_break_data", 32'(data_out), 32'h81);
    chk("after_break_valid", 32'(data_valid), 32'd1);
    consume();

    // Back-to-back frames without consuming
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1, -1);
    chk("ovr_first", 32'(overrun), 32'd0);
    send_frame(8'h22, 1'b1, -1, -1);
    idle(16);
    chk("ovr_data", 32'(data_out), 32'h22);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(data_valid), 32'd1);
    consume();
    chk("ovr_clr_valid", 32'(data_valid), 32'd0);
    chk("ovr_clr_flag", 32'(overrun), 32'd0);

    // Reset in data bit 4 while a byte is held
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, -1, -1);
    idle(16);
    chk("pre_rst_valid", 32'(data_valid), 32'd1);
    send_frame(8'hE7, 1'b1, -1, 5);
    rx_bit = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    idle(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(16);
    chk("post_rst_data", 32'(data_out), 32'h5A);
    chk("post_rst_valid", 32'(data_valid), 32'd1);
    consume();

    // High glitch on sample 7 of data bit 2
`ifdef UART_RX_MAJORITY_EN
    gexp = 8'h00;
`else
    gexp = 8'h04;
`endif
    exp_q.push_back(gexp);
    send_frame(8'h00, 1'b1, 3, -1);
    idle(16);
    chk("sample_glitch_data", 32'(data_out), 32'(gexp));
    consume();
    idle(BIT_CLKS);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
